decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with an optional auto-scan mode. In direct mode it decodes an `IN_W`-bit code, presented with a valid strobe, into a `2**IN_W`-bit one-hot output. In scan mode it steps the active output up or down at a programmable rate. It sits between control logic and LED, digit-select or row-select drivers, and replaces pure combinational 3-to-8 decoding wherever glitch-free registered outputs, blanking or chaser sequencing is needed.

---
 rtl/decoder_scan.sv | 69 ++++++
 tb/tb_decoder_scan.sv | 99 +++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with blanking and auto-scan chaser mode
module decoder_scan #(
  parameter int          IN_W    = 3,
  parameter int unsigned CNT_MAX = 24_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              mode,
  input  logic              scan_dir,
  input  logic              in_vld,
  input  logic [IN_W-1:0]   in_code,
  output logic [2**IN_W-1:0] out,
  output logic [IN_W-1:0]   out_idx,
  output logic              out_upd,
  output logic              wrap
);
  localparam int OUT_W = 2**IN_W;
  localparam int CW = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic upd_q, upd_d, wrap_q, wrap_d;
  always_comb begin
    state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
    idx_d = idx_q;
    cnt_d = '0;
    upd_d = 1'b0;
    wrap_d = 1'b0;
    // a load always wins over a step; SCAN entry only restarts the phase
    if (state_d != IDLE && in_vld) begin
      idx_d = in_code;
      upd_d = 1'b1;
    end else if (state_d == SCAN && state_q == SCAN) begin
      if (cnt_q == CMAX) begin
        idx_d = scan_dir ? idx_q - IN_W'(1) : idx_q + IN_W'(1);
        upd_d = 1'b1;
        wrap_d = scan_dir ? (idx_q == '0) : (&idx_q);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    out_d = (state_d == IDLE) ? '0 : OUT_W'(1) << idx_d;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      upd_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      upd_q <= upd_d;
      wrap_q <= wrap_d;
    end
  end
  assign out = out_q;
  assign out_idx = idx_q;
  assign out_upd = upd_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed vectors feed a scoreboard queue; a monitor checks every registered cycle
module tb_decoder_scan;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic en = 1'b0, mode = 1'b0, scan_dir = 1'b0, in_vld = 1'b0;
  logic [2:0] in_code = '0;
  logic [7:0] out;
  logic [2:0] out_idx;
  logic out_upd, wrap;
  typedef struct packed {
    logic [7:0] o;
    logic [2:0] i;
    logic u;
    logic w;
  } exp_t;
  exp_t exp_q[$];
  int tag_q[$];
  int n_chk = 0, n_fail = 0, vec = 0;
  decoder_scan #(.IN_W(3), .CNT_MAX(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode), .scan_dir(scan_dir),
    .in_vld(in_vld), .in_code(in_code), .out(out), .out_idx(out_idx),
    .out_upd(out_upd), .wrap(wrap)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic t(input logic r, input logic e, input logic m, input logic d, input logic v,
                   input logic [2:0] c, input logic [7:0] eo, input logic [2:0] ei,
                   input logic eu, input logic ew);
    @(negedge sys_clk);
    sys_rst = r; en = e; mode = m; scan_dir = d; in_vld = v; in_code = c;
    exp_q.push_back('{o: eo, i: ei, u: eu, w: ew});
    tag_q.push_back(vec);
    vec++;
  endtask
  task automatic hold(input int n, input logic e, input logic d, input logic [7:0] eo,
                      input logic [2:0] ei);
    for (int k = 0; k < n; k++) t(0, e, 1, d, 0, 0, eo, ei, 0, 0);
  endtask
  always @(posedge sys_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t ex;
      int tg;
      ex = exp_q.pop_front();
      tg = tag_q.pop_front();
      n_chk++;
      if ({out, out_idx, out_upd, wrap} !== ex) begin
        n_fail++;
        $display("FAIL vec%0d: got out=%h idx=%0d upd=%b wrap=%b, want out=%h idx=%0d upd=%b wrap=%b",
                 tg, out, out_idx, out_upd, wrap, ex.o, ex.i, ex.u, ex.w);
      end
    end
  end
  initial begin
    // reset dominance
    for (int k = 0; k < 3; k++) t(1, 1, 1, 0, 1, 5, 8'h00, 0, 0, 0);
    // direct decode of every code
    for (int c = 0; c < 8; c++) t(0, 1, 0, 0, 1, 3'(c), 8'(1 << c), 3'(c), 1, 0);
    // scan up through the wrap
    t(0, 1, 0, 0, 1, 6, 8'h40, 6, 1, 0);
    hold(4, 1, 0, 8'h40, 6);
    t(0, 1, 1, 0, 0, 0, 8'h80, 7, 1, 0);
    hold(3, 1, 0, 8'h80, 7);
    t(0, 1, 1, 0, 0, 0, 8'h01, 0, 1, 1);
    // load colliding with a down step
    hold(3, 1, 1, 8'h01, 0);
    t(0, 1, 1, 1, 1, 5, 8'h20, 5, 1, 0);
    hold(3, 1, 1, 8'h20, 5);
    t(0, 1, 1, 1, 0, 0, 8'h10, 4, 1, 0);
    hold(3, 1, 1, 8'h10, 4);
    t(0, 1, 1, 1, 0, 0, 8'h08, 3, 1, 0);
    hold(3, 1, 1, 8'h08, 3);
    t(0, 1, 1, 1, 0, 0, 8'h04, 2, 1, 0);
    // blank mid-scan, then re-enable and continue down through the wrap
    hold(5, 0, 1, 8'h00, 2);
    hold(4, 1, 1, 8'h04, 2);
    t(0, 1, 1, 1, 0, 0, 8'h02, 1, 1, 0);
    hold(3, 1, 1, 8'h02, 1);
    t(0, 1, 1, 1, 0, 0, 8'h01, 0, 1, 0);
    hold(3, 1, 1, 8'h01, 0);
    t(0, 1, 1, 1, 0, 0, 8'h80, 7, 1, 1);
    // reset mid-scan
    t(0, 1, 1, 0, 1, 5, 8'h20, 5, 1, 0);
    t(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    hold(4, 1, 0, 8'h01, 0);
    t(0, 1, 1, 0, 0, 0, 8'h02, 1, 1, 0);
    // mode change to DIRECT with a same-cycle load, then blank ignores in_vld
    t(0, 1, 0, 0, 1, 3, 8'h08, 3, 1, 0);
    t(0, 0, 0, 0, 1, 6, 8'h00, 3, 0, 0);
    t(0, 1, 0, 0, 0, 0, 8'h08, 3, 0, 0);
    repeat (3) @(negedge sys_clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
